imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of first instruction word written.
REQ-002 SHALL have parameter TIMEOUT, default 1024, maximum idle cycles between accepted bytes during a load.
REQ-003 SHALL have port Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  single-cycle request to begin a load.
REQ-006 SHALL have port Word_Count  input  16  number of 32-bit instruction words to load, sampled when Start is accepted.
REQ-007 SHALL have port Byte_In  input  8  incoming program byte.
REQ-008 SHALL have port Byte_Valid  input  1  Byte_In is valid.
REQ-009 SHALL have port Byte_Ready  output  1  loader can accept a byte this cycle.
REQ-010 SHALL have port Imem_Wr_En  output  1  instruction-memory write strobe.
REQ-011 SHALL have port Imem_Wr_Addr  output  32  instruction-memory byte address.
REQ-012 SHALL have port Imem_Wr_Data  output  32  instruction word to write.
REQ-013 SHALL have port Core_Reset  output  1  holds the processor core in reset while high.
REQ-014 SHALL have ports Busy, Done, Error  output  1 each  load in progress / load complete / load aborted.

Function
REQ-015 SHALL implement FSM states IDLE, RECV, WRITE, DONE, ERR.
REQ-016 Start in IDLE, DONE or ERR SHALL latch Word_Count, clear word index, byte index and timeout counter, clear Done and Error, assert Core_Reset, and enter RECV next cycle. If the latched count is 0, it SHALL enter DONE instead.
REQ-017 Start in RECV or WRITE SHALL be ignored.
REQ-018 A byte SHALL be accepted only on a cycle with Byte_Valid=1 and Byte_Ready=1. Byte_Ready SHALL be 1 only in RECV.
REQ-019 Bytes SHALL be packed big-endian: 1st accepted byte to [31:24], 2nd to [23:16], 3rd to [15:8], 4th to [7:0].
REQ-020 Acceptance of the 4th byte SHALL move to WRITE. The next cycle SHALL be the only cycle with Imem_Wr_En=1, with Imem_Wr_Addr=BASE_ADDR+4*word_index (mod 2^32) and Imem_Wr_Data=the assembled word.
REQ-021 After WRITE, word_index SHALL increment and byte index SHALL return to 0. If word_index+1 equals the latched count, the FSM SHALL enter DONE; otherwise it SHALL return to RECV.
REQ-022 Imem_Wr_Addr and Imem_Wr_Data SHALL be 0 whenever Imem_Wr_En=0.
REQ-023 In RECV the timeout counter SHALL increment each cycle with no accepted byte and clear on every accepted byte. When it reaches TIMEOUT, the FSM SHALL enter ERR and discard any partial word.
REQ-024 DONE SHALL drive Done=1 and Core_Reset=0 and hold until the next Start or Reset.
REQ-025 ERR SHALL drive Error=1 and Core_Reset=1 and hold until the next Start or Reset.
REQ-026 Busy SHALL be 1 exactly in RECV and WRITE.
REQ-027 Load throughput SHALL be at most 5 cycles per word when Byte_Valid is held high.

Reset
REQ-028 Reset SHALL take priority over all other inputs, including Start in the same cycle.
REQ-029 On Reset the FSM SHALL enter IDLE with outputs Core_Reset=1, Byte_Ready=0, Imem_Wr_En=0, Imem_Wr_Addr=0, Imem_Wr_Data=0, Busy=0, Done=0 and Error=0, and all counters cleared.
REQ-030 Reset during RECV or WRITE SHALL abort the load with no further memory write.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the BASE_ADDR and TIMEOUT defaults, and the 32-bit word width constant.
REQ-032 Byte packing (byte index plus 32-bit shift register) SHALL be one sub-module, word_assembler. The FSM, counters and address generation SHALL stay in imem_loader.

Verification
REQ-033 Start with Word_Count=2, bytes 20 08 00 05 8C 09 00 04 streamed back-to-back SHALL produce:
- a write of 0x20080005 to address 0x0;
- a write of 0x8C090004 to address 0x4;
- then Done=1 and Core_Reset=0.
REQ-034 Start with Word_Count=0 SHALL give Done=1 two cycles after Start, with no Imem_Wr_En pulse.
REQ-035 With Word_Count=1, BASE_ADDR=0x400 and Byte_Valid toggling every other cycle, the bench SHALL see a single write of the word to 0x400, with Byte_Ready low during WRITE.
REQ-036 With TIMEOUT=8, sending 2 bytes then stalling SHALL give Error=1 after 8 idle cycles, with Core_Reset=1 and no write. A following Start with valid data SHALL load successfully.
REQ-037 Asserting Reset on the cycle the 4th byte is accepted SHALL produce no write, return to IDLE, and leave Core_Reset=1.
REQ-038 Start asserted during RECV SHALL not change word_index or the latched count.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding,
// parameter defaults, word geometry and the write-address helper.
package imem_loader_pkg;

    // Instruction word and byte geometry
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;
    localparam int unsigned CNT_W          = 16;

    // Defaults for the loader parameters
    localparam logic [WORD_W-1:0] DEFAULT_BASE_ADDR = 32'h0000_0000;
    localparam int unsigned       DEFAULT_TIMEOUT   = 1024;

    // Loader FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    // Byte address of instruction word idx; wraps modulo 2^32.
    function automatic logic [WORD_W-1:0] word_addr(
        input logic [WORD_W-1:0] base,
        input logic [CNT_W-1:0]  idx
    );
        return base + {{(WORD_W - CNT_W - 2){1'b0}}, idx, 2'b00};
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs a stream of bytes into 32-bit words, most significant byte first.
// The first accepted byte of a word ends up in [31:24], the fourth in [7:0].
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              accept,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word_next,
    output logic              word_done
);

    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [WORD_W-1:0] shift_q, shift_d;

    // Word as it will look once the byte on byte_in is shifted in; on the
    // fourth byte this is the complete big-endian instruction word.
    assign word_next = {shift_q[WORD_W-BYTE_W-1:0], byte_in};
    assign word_done = accept && (byte_idx_q == 2'(BYTES_PER_WORD - 1));

    // Byte index advances per accepted byte and wraps to 0 after the fourth
    always_comb begin
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        if (clear) begin
            byte_idx_d = '0;
        end else if (accept) begin
            byte_idx_d = byte_idx_q + 2'd1;
            shift_d    = word_next;
        end
    end

    // Byte index is control state and is reset
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx_q <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
        end
    end

    // Shift register holds only data; stale bytes are shifted out within a word
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a program as a byte stream, packs it
// into 32-bit words and writes them to consecutive word addresses while the
// processor core is held in reset. Releases the core once the load completes.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [CNT_W-1:0]  Word_Count,
    input  logic [BYTE_W-1:0] Byte_In,
    input  logic              Byte_Valid,
    output logic              Byte_Ready,
    output logic              Imem_Wr_En,
    output logic [WORD_W-1:0] Imem_Wr_Addr,
    output logic [WORD_W-1:0] Imem_Wr_Data,
    output logic              Core_Reset,
    output logic              Busy,
    output logic              Done,
    output logic              Error
);

    localparam int unsigned     TO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  word_idx_q, word_idx_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

    logic              byte_ready_q, byte_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [WORD_W-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;
    logic              core_reset_q, core_reset_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              byte_accept;
    logic              asm_clear;
    logic [WORD_W-1:0] asm_word;
    logic              asm_word_done;

    // Byte_Ready is a registered copy of "state is RECV", so this is exactly
    // a handshake in RECV.
    assign byte_accept = Byte_Valid && byte_ready_q;

    word_assembler u_word_assembler (
        .clk       (Clock),
        .rst       (Reset),
        .clear     (asm_clear),
        .accept    (byte_accept),
        .byte_in   (Byte_In),
        .word_next (asm_word),
        .word_done (asm_word_done)
    );

    // Next state, counters, write port and registered status outputs
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        to_cnt_d   = to_cnt_q;
        wr_addr_d  = '0;
        wr_data_d  = '0;
        asm_clear  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (Start) begin
                    count_d    = Word_Count;
                    word_idx_d = '0;
                    to_cnt_d   = '0;
                    asm_clear  = 1'b1;
                    state_d    = (Word_Count == '0) ? ST_DONE : ST_RECV;
                end
            end

            ST_RECV: begin
                if (byte_accept) begin
                    to_cnt_d = '0;
                    if (asm_word_done) begin
                        // Write port is loaded here so the strobe, address and
                        // data all appear together in the WRITE cycle.
                        state_d   = ST_WRITE;
                        wr_addr_d = word_addr(BASE_ADDR, word_idx_q);
                        wr_data_d = asm_word;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    // Source went quiet: abandon the load and any partial word
                    state_d   = ST_ERR;
                    to_cnt_d  = '0;
                    asm_clear = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            ST_WRITE: begin
                word_idx_d = word_idx_q + 1'b1;
                state_d    = (word_idx_q + 1'b1 == count_q) ? ST_DONE : ST_RECV;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register in step
        // with the state they describe.
        byte_ready_d = (state_d == ST_RECV);
        wr_en_d      = (state_d == ST_WRITE);
        busy_d       = (state_d == ST_RECV) || (state_d == ST_WRITE);
        done_d       = (state_d == ST_DONE);
        error_d      = (state_d == ST_ERR);
        core_reset_d = (state_d != ST_DONE);
    end

    // Loader FSM with registered outputs; Reset overrides every input
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            word_idx_q   <= '0;
            to_cnt_q     <= '0;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            word_idx_q   <= word_idx_d;
            to_cnt_q     <= to_cnt_d;
            byte_ready_q <= byte_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign Byte_Ready   = byte_ready_q;
    assign Imem_Wr_En   = wr_en_q;
    assign Imem_Wr_Addr = wr_addr_q;
    assign Imem_Wr_Data = wr_data_q;
    assign Core_Reset   = core_reset_q;
    assign Busy         = busy_q;
    assign Done         = done_q;
    assign Error        = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader. Two instances: u_dut0 with default parameters,
// u_dut1 with BASE_ADDR=0x400 and TIMEOUT=8. Expected writes come from the
// list of words each load is built from.
module tb_imem_loader;

    // Status vector {Core_Reset, Busy, Done, Error, Byte_Ready, Imem_Wr_En}
    localparam logic [5:0] S_IDLE = 6'b100000;
    localparam logic [5:0] S_RECV = 6'b110010;
    localparam logic [5:0] S_DONE = 6'b001000;
    localparam logic [5:0] S_ERR  = 6'b100100;

    logic        clk;
    logic        rst_i   [2];
    logic        start_i [2];
    logic [15:0] wc_i    [2];
    logic [7:0]  bin_i   [2];
    logic        bval_i  [2];
    logic        bready_o[2];
    logic        wen_o   [2];
    logic [31:0] waddr_o [2];
    logic [31:0] wdata_o [2];
    logic        crst_o  [2];
    logic        busy_o  [2];
    logic        done_o  [2];
    logic        err_o   [2];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          viol     = 0;
    bit          mon_en   = 1'b0;

    logic [64:0] wq[$];        // observed writes {dut, addr, data}
    logic [31:0] ld_words[$];  // words of the current load
    logic [7:0]  fb[$];        // byte stream of the current load
    int          fb_idx;

    imem_loader u_dut0 (
        .Clock(clk), .Reset(rst_i[0]), .Start(start_i[0]), .Word_Count(wc_i[0]),
        .Byte_In(bin_i[0]), .Byte_Valid(bval_i[0]), .Byte_Ready(bready_o[0]),
        .Imem_Wr_En(wen_o[0]), .Imem_Wr_Addr(waddr_o[0]), .Imem_Wr_Data(wdata_o[0]),
        .Core_Reset(crst_o[0]), .Busy(busy_o[0]), .Done(done_o[0]), .Error(err_o[0])
    );

    imem_loader #(.BASE_ADDR(32'h0000_0400), .TIMEOUT(8)) u_dut1 (
        .Clock(clk), .Reset(rst_i[1]), .Start(start_i[1]), .Word_Count(wc_i[1]),
        .Byte_In(bin_i[1]), .Byte_Valid(bval_i[1]), .Byte_Ready(bready_o[1]),
        .Imem_Wr_En(wen_o[1]), .Imem_Wr_Addr(waddr_o[1]), .Imem_Wr_Data(wdata_o[1]),
        .Core_Reset(crst_o[1]), .Busy(busy_o[1]), .Done(done_o[1]), .Error(err_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    // Write recorder and cycle invariants, sampled mid-cycle
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                if (wen_o[d] === 1'b1) wq.push_back({1'(d), waddr_o[d], wdata_o[d]});
                else if (waddr_o[d] !== 32'h0 || wdata_o[d] !== 32'h0) viol++;
                if (wen_o[d] === 1'b1 && bready_o[d] !== 1'b0) viol++;
                if (busy_o[d] !== (bready_o[d] | wen_o[d])) viol++;
                if (done_o[d] === 1'b1 && (busy_o[d] !== 1'b0 || crst_o[d] !== 1'b0)) viol++;
                if (err_o[d] === 1'b1 && crst_o[d] !== 1'b1) viol++;
            end
        end
    end

    function automatic logic [5:0] status(input int d);
        return {crst_o[d], busy_o[d], done_o[d], err_o[d], bready_o[d], wen_o[d]};
    endfunction

    function automatic logic [31:0] base_of(input int d);
        return (d == 0) ? 32'h0000_0000 : 32'h0000_0400;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_load(input int d, input logic [15:0] n);
        start_i[d] = 1'b1;
        wc_i[d]    = n;
        tick();
        start_i[d] = 1'b0;
    endtask

    // Byte stream for ld_words, most significant byte of each word first
    task automatic words_to_bytes();
        fb.delete();
        fb_idx = 0;
        foreach (ld_words[w]) begin
            logic [31:0] word;
            word = ld_words[w];
            for (int b = 3; b >= 0; b--) fb.push_back(word[8*b +: 8]);
        end
    endtask

    task automatic random_words(input int n);
        ld_words.delete();
        for (int w = 0; w < n; w++) ld_words.push_back($urandom);
        words_to_bytes();
    endtask

    // Offer bytes until 'upto' have been accepted; gaps bounded by gap_max
    task automatic feed(input int d, input int upto, input int gap_max, input bit toggle,
                        inout int cyc);
        int   gap;
        int   budget;
        logic acc;
        gap    = 0;
        budget = cyc + 16 * (upto - fb_idx) + 64;
        while (fb_idx < upto && cyc < budget) begin
            if (toggle) bval_i[d] = (cyc % 2 == 0);
            else        bval_i[d] = (gap == 0);
            bin_i[d] = bval_i[d] ? fb[fb_idx] : 8'h00;
            acc = bval_i[d] && bready_o[d];
            tick();
            cyc++;
            if (acc) begin
                fb_idx++;
                gap = $urandom_range(0, gap_max);
            end else if (gap > 0) begin
                gap--;
            end
        end
        bval_i[d] = 1'b0;
        bin_i[d]  = 8'h00;
        n_checks++;
        if (fb_idx != upto) begin
            n_fail++;
            $display("FAIL feed_d%0d: accepted %0d bytes, required %0d", d, fb_idx, upto);
        end
    endtask

    task automatic wait_end(input int d, inout int cyc);
        int lim;
        lim = cyc + 32;
        while (done_o[d] !== 1'b1 && err_o[d] !== 1'b1 && cyc < lim) begin
            tick();
            cyc++;
        end
    endtask

    // Complete load of ld_words into dut d, checked against the word list
    task automatic run_load(input int d, input int gap_max, input bit toggle,
                            input string tag, output int cyc);
        logic [64:0] exp;
        wq.delete();
        cyc = 0;
        begin_load(d, 16'(ld_words.size()));
        feed(d, fb.size(), gap_max, toggle, cyc);
        wait_end(d, cyc);
        n_checks++;
        if (status(d) !== S_DONE) begin
            n_fail++;
            $display("FAIL %s_status: got %b, required %b", tag, status(d), S_DONE);
        end
        n_checks++;
        if (wq.size() != ld_words.size()) begin
            n_fail++;
            $display("FAIL %s_nwrites: got %0d, required %0d", tag, wq.size(), ld_words.size());
        end
        for (int i = 0; i < ld_words.size() && i < wq.size(); i++) begin
            exp = {1'(d), base_of(d) + 32'(4 * i), ld_words[i]};
            n_checks++;
            if (wq[i] !== exp) begin
                n_fail++;
                $display("FAIL %s_write%0d: got addr %h data %h, required addr %h data %h",
                         tag, i, wq[i][63:32], wq[i][31:0], exp[63:32], exp[31:0]);
            end
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst_i[d] = 1'b1; start_i[d] = 1'b1; wc_i[d] = 16'd3;
            bval_i[d] = 1'b1; bin_i[d] = 8'hA5;
        end
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            start_i[d] = 1'b0; bval_i[d] = 1'b0; bin_i[d] = 8'h00;
        end
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (status(d) !== S_IDLE) begin
                n_fail++;
                $display("FAIL reset_status_d%0d: got %b, required %b", d, status(d), S_IDLE);
            end
            n_checks++;
            if ({waddr_o[d], wdata_o[d]} !== 64'h0) begin
                n_fail++;
                $display("FAIL reset_port_d%0d: got %h, required 0", d, {waddr_o[d], wdata_o[d]});
            end
        end
        for (int d = 0; d < 2; d++) rst_i[d] = 1'b0;
        tick();
        mon_en = 1'b1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (status(d) !== S_IDLE) begin
                n_fail++;
                $display("FAIL post_reset_d%0d: got %b, required %b", d, status(d), S_IDLE);
            end
        end
    endtask

    task automatic test_two_words();
        int cyc;
        ld_words.delete();
        ld_words.push_back(32'h2008_0005);
        ld_words.push_back(32'h8C09_0004);
        words_to_bytes();
        run_load(0, 0, 1'b0, "two_words", cyc);
        n_checks++;
        if (cyc > 10) begin
            n_fail++;
            $display("FAIL two_words_throughput: got %0d cycles, required <= 10", cyc);
        end
    endtask

    task automatic test_zero_count();
        rst_i[0] = 1'b1;
        tick();
        rst_i[0] = 1'b0;
        wq.delete();
        begin_load(0, 16'd0);
        tick();
        n_checks++;
        if (status(0) !== S_DONE) begin
            n_fail++;
            $display("FAIL zero_count_status: got %b, required %b", status(0), S_DONE);
        end
        tick();
        n_checks++;
        if (wq.size() != 0) begin
            n_fail++;
            $display("FAIL zero_count_writes: got %0d, required 0", wq.size());
        end
    endtask

    task automatic test_reset_priority();
        rst_i[0] = 1'b1; start_i[0] = 1'b1; wc_i[0] = 16'd3;
        tick();
        rst_i[0] = 1'b0; start_i[0] = 1'b0;
        n_checks++;
        if (status(0) !== S_IDLE) begin
            n_fail++;
            $display("FAIL reset_priority: got %b, required %b", status(0), S_IDLE);
        end
        tick();
        n_checks++;
        if (status(0) !== S_IDLE) begin
            n_fail++;
            $display("FAIL reset_priority_hold: got %b, required %b", status(0), S_IDLE);
        end
    endtask

    task automatic test_toggle_valid();
        int cyc;
        random_words(1);
        run_load(1, 0, 1'b1, "toggle", cyc);
    endtask

    task automatic test_timeout();
        int cyc;
        random_words(2);
        wq.delete();
        cyc = 0;
        begin_load(1, 16'd2);
        feed(1, 2, 0, 1'b0, cyc);
        for (int i = 0; i < 7; i++) tick();
        n_checks++;
        if (status(1) !== S_RECV) begin
            n_fail++;
            $display("FAIL timeout_early: got %b after 7 idle, required %b", status(1), S_RECV);
        end
        tick();
        n_checks++;
        if (status(1) !== S_ERR) begin
            n_fail++;
            $display("FAIL timeout_err: got %b after 8 idle, required %b", status(1), S_ERR);
        end
        n_checks++;
        if (wq.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_writes: got %0d, required 0", wq.size());
        end
        random_words(2);
        run_load(1, 1, 1'b0, "after_err", cyc);
    endtask

    task automatic test_reset_last_byte();
        int cyc;
        random_words(1);
        wq.delete();
        cyc = 0;
        begin_load(1, 16'd1);
        feed(1, 3, 0, 1'b0, cyc);
        bval_i[1] = 1'b1; bin_i[1] = fb[3]; rst_i[1] = 1'b1;
        tick();
        bval_i[1] = 1'b0; bin_i[1] = 8'h00; rst_i[1] = 1'b0;
        n_checks++;
        if (status(1) !== S_IDLE) begin
            n_fail++;
            $display("FAIL rst_last_byte_status: got %b, required %b", status(1), S_IDLE);
        end
        tick(); tick(); tick();
        n_checks++;
        if (wq.size() != 0 || status(1) !== S_IDLE) begin
            n_fail++;
            $display("FAIL rst_last_byte_after: writes %0d status %b, required 0 and %b",
                     wq.size(), status(1), S_IDLE);
        end
    endtask

    task automatic test_start_during_recv();
        int          cyc;
        logic [64:0] exp;
        random_words(2);
        wq.delete();
        cyc = 0;
        begin_load(1, 16'd2);
        feed(1, 6, 0, 1'b0, cyc);
        start_i[1] = 1'b1; wc_i[1] = 16'd5;
        tick();
        cyc++;
        start_i[1] = 1'b0;
        n_checks++;
        if (status(1) !== S_RECV) begin
            n_fail++;
            $display("FAIL start_in_recv_status: got %b, required %b", status(1), S_RECV);
        end
        feed(1, 8, 0, 1'b0, cyc);
        wait_end(1, cyc);
        n_checks++;
        if (status(1) !== S_DONE || wq.size() != 2) begin
            n_fail++;
            $display("FAIL start_in_recv_end: status %b writes %0d, required %b and 2",
                     status(1), wq.size(), S_DONE);
        end
        for (int i = 0; i < 2 && i < wq.size(); i++) begin
            exp = {1'b1, 32'h400 + 32'(4 * i), ld_words[i]};
            n_checks++;
            if (wq[i] !== exp) begin
                n_fail++;
                $display("FAIL start_in_recv_write%0d: got %h, required %h", i, wq[i], exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        for (int k = 0; k < 8; k++) begin
            random_words($urandom_range(1, 5));
            run_load(k % 2, $urandom_range(0, 3), 1'b0, $sformatf("b2b%0d", k), cyc);
        end
    endtask

    task automatic test_invariants();
        n_checks++;
        if (viol != 0) begin
            n_fail++;
            $display("FAIL invariants: got %0d violations, required 0", viol);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_i[d] = 1'b1; start_i[d] = 1'b0; wc_i[d] = 16'd0;
            bin_i[d] = 8'h00; bval_i[d] = 1'b0;
        end
        test_reset();
        test_two_words();
        test_zero_count();
        test_reset_priority();
        test_toggle_valid();
        test_timeout();
        test_reset_last_byte();
        test_start_during_recv();
        test_back_to_back();
        tick();
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
